// File: rtl/view_pkg.sv
// Shared definitions for the sprite view path: direction encodings, colour type
// and the default transparency key.
package view_pkg;

    typedef logic [11:0] color_t;

    typedef enum logic [3:0] {
        DIR_RIGHT = 4'b0001,
        DIR_LEFT  = 4'b0010,
        DIR_UP    = 4'b0100,
        DIR_DOWN  = 4'b1000
    } dir_e;

    localparam color_t TRANSPARENT_KEY = 12'h000;

    function automatic logic is_onehot(input logic [3:0] d);
        return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Sprite window test and orientation-aware ROM address generation; rom_addr is
// registered one cycle after the scan position and forced to 0 outside the window.
module sprite_addr_gen
    import view_pkg::*;
#(
    parameter int   SPR_W  = 30,
    parameter int   SPR_H  = 30,
    parameter int   FRAMES = 4,
    parameter int   FW     = 2,
    localparam int  ADDR_W = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hC,
    input  logic [9:0]        vC,
    input  logic [9:0]        xs,
    input  logic [9:0]        ys,
    input  dir_e              dir,
    input  logic [FW-1:0]     anim_frame,
    output logic              in_win,
    output logic [ADDR_W-1:0] rom_addr
);

    logic [10:0]       h_ext, v_ext, x_beg, y_beg, x_end, y_end;
    logic [9:0]        r, c, row, col;
    logic [ADDR_W-1:0] addr_next;

    // 11-bit compare so a sprite near column/row 1023 never wraps into 0.
    assign h_ext  = {1'b0, hC};
    assign v_ext  = {1'b0, vC};
    assign x_beg  = {1'b0, xs};
    assign y_beg  = {1'b0, ys};
    assign x_end  = x_beg + 11'(SPR_W);
    assign y_end  = y_beg + 11'(SPR_H);
    assign in_win = (h_ext >= x_beg) && (h_ext < x_end) &&
                    (v_ext >= y_beg) && (v_ext < y_end);

    assign r = vC - ys;
    assign c = hC - xs;

    always_comb begin
        // NOTE: defaults first so every path assigns row/col and no latch is inferred.
        row = r;
        col = c;
        case (dir)
            DIR_LEFT:  col = 10'(SPR_W - 1) - c;
            DIR_UP:    begin row = c;                   col = r; end
            DIR_DOWN:  begin row = 10'(SPR_H - 1) - c;  col = r; end
            default:   ;
        endcase
    end

    assign addr_next = ADDR_W'(anim_frame) * ADDR_W'(SPR_W * SPR_H)
                     + ADDR_W'(row) * ADDR_W'(SPR_W)
                     + ADDR_W'(col);

    // NOTE: registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rom_addr <= '0;
        else     rom_addr <= in_win ? addr_next : '0;
    end

endmodule

// File: rtl/sprite_view.sv
// Animated, orientable sprite overlay: frame tick, shadow registers, animation
// counter and ROM-latency pipeline. Define SPRITE_TRANSPARENCY_EN to key out TRANSPARENT.
module sprite_view
    import view_pkg::*;
#(
    parameter int     SPR_W       = 30,
    parameter int     SPR_H       = 30,
    parameter int     FRAMES      = 4,
    parameter int     FRAME_DIV   = 8,
    parameter int     ROM_LAT     = 1,
    parameter color_t TRANSPARENT = TRANSPARENT_KEY,
    localparam int    ADDR_W      = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        vC,
    input  logic [9:0]        hC,
    input  logic [9:0]        xpos,
    input  logic [9:0]        ypos,
    input  logic [3:0]        direction,
    input  logic              moving,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic              fill,
    output logic [11:0]       color_data
);

    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

`ifdef SPRITE_TRANSPARENCY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic          at_origin, origin_q, frame_tick;
    logic [9:0]    xs_q, ys_q;
    dir_e          dir_q;
    logic [DW-1:0] div_q;
    logic [FW-1:0] frame_q;
    logic          in_win, pix_on;
    logic [ROM_LAT:0] win_pipe;

    // Tick only on entry to (0,0), not while the scan position rests there.
    assign at_origin  = (vC == 10'd0) && (hC == 10'd0);
    assign frame_tick = at_origin && !origin_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            origin_q <= 1'b0;
            xs_q     <= '0;
            ys_q     <= '0;
            dir_q    <= DIR_RIGHT;
        end else begin
            origin_q <= at_origin;
            if (frame_tick) begin
                xs_q <= xpos;
                ys_q <= ypos;
                if (is_onehot(direction)) dir_q <= dir_e'(direction);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            frame_q <= '0;
        end else if (frame_tick) begin
            if (div_q == DW'(FRAME_DIV - 1)) begin
                div_q <= '0;
                if (moving)
                    frame_q <= (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + FW'(1);
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    sprite_addr_gen #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .FRAMES (FRAMES),
        .FW     (FW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .hC         (hC),
        .vC         (vC),
        .xs         (xs_q),
        .ys         (ys_q),
        .dir        (dir_q),
        .anim_frame (frame_q),
        .in_win     (in_win),
        .rom_addr   (rom_addr)
    );

    // Window flag tracks the address through the ROM so fill lines up with rom_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_pipe <= '0;
        end else begin
            win_pipe[0] <= in_win;
            for (int i = 1; i <= ROM_LAT; i++) win_pipe[i] <= win_pipe[i-1];
        end
    end

    assign pix_on = win_pipe[ROM_LAT] && !(KEY_EN && (rom_data == TRANSPARENT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill       <= 1'b0;
            color_data <= '0;
        end else begin
            fill       <= pix_on;
            color_data <= pix_on ? rom_data : 12'h000;
        end
    end

endmodule

// File: doc/sprite_view.md
SPRITE_VIEW -- requirements
Module: sprite_view

Interface
REQ-001 SHALL have parameter SPR_W, default 30: sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 30: sprite height in pixels; must equal SPR_W when vertical orientations are used.
REQ-003 SHALL have parameter FRAMES, default 4: number of animation frames stored in ROM.
REQ-004 SHALL have parameter FRAME_DIV, default 8: video frames per animation step.
REQ-005 SHALL have parameter ROM_LAT, default 1: sprite ROM read latency in clk cycles.
REQ-006 SHALL have parameter TRANSPARENT, default 12'h000: transparency colour key.
REQ-007 SHALL have port clk, input, 1: single system clock.
REQ-008 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-009 SHALL have ports vC and hC, input, 10 each: current scan row and column.
REQ-010 SHALL have ports xpos and ypos, input, 10 each: sprite top-left position.
REQ-011 SHALL have port direction, input, 4: one-hot, bit0 right, bit1 left, bit2 up, bit3 down.
REQ-012 SHALL have port moving, input, 1: animation advances only while high.
REQ-013 SHALL have port rom_addr, output, ADDR_W = clog2(FRAMES*SPR_W*SPR_H): external ROM address.
REQ-014 SHALL have port rom_data, input, 12: ROM pixel returned ROM_LAT cycles after rom_addr.
REQ-015 SHALL have port fill, output, 1: sprite pixel owns the current output position.
REQ-016 SHALL have port color_data, output, 12: pixel colour, valid when fill=1.

Function
REQ-017 SHALL raise a frame tick on the first clk cycle in which vC==0 && hC==0 (edge-detected; no second tick while the position holds).
REQ-018 SHALL latch xpos, ypos and direction into shadow registers on the frame tick only, so position and orientation never change mid-frame.
REQ-019 SHALL keep the previous shadow direction when direction is not one-hot (including 4'b0000).
REQ-020 SHALL count frame ticks modulo FRAME_DIV; on wrap with moving=1, anim_frame SHALL increment modulo FRAMES (FRAMES-1 wraps to 0); with moving=0, anim_frame SHALL hold.
REQ-021 SHALL compute the window as xs<=hC<xs+SPR_W and ys<=vC<ys+SPR_H in 11-bit arithmetic, with no wrap past 1023.
REQ-022 SHALL form r=vC-ys and c=hC-xs, then derive the ROM coordinates (row,col) by direction:
- right: (r, c)
- left: (r, SPR_W-1-c)
- up: (c, r)
- down: (SPR_H-1-c, r)
REQ-023 SHALL drive rom_addr = anim_frame*SPR_W*SPR_H + row*SPR_W + col, registered one cycle after hC/vC, and 0 outside the window.
REQ-024 SHALL delay the window flag through a ROM_LAT+1 stage pipeline, so fill and color_data align with the hC/vC presented ROM_LAT+2 cycles earlier; latency is constant.
REQ-025 SHALL register color_data = rom_data when the delayed window is 1, and 12'h000 otherwise.

Reset
REQ-026 SHALL, while rst is high, asynchronously clear:
- fill=0, color_data=0, rom_addr=0
- anim_frame=0, frame divider=0, pipeline=0, tick detector=0
- shadow xs=ys=0, shadow direction=4'b0001
REQ-027 SHALL, when rst asserts mid-frame, discard pipeline contents; the first valid fill follows reset release by ROM_LAT+2 cycles, using shadow position 0,0 until the next frame tick.

Configuration
REQ-028 SHALL, with SPRITE_TRANSPARENCY_EN defined, force fill=0 and color_data=0 for window pixels whose rom_data equals TRANSPARENT.
REQ-029 SHALL, without SPRITE_TRANSPARENCY_EN, assert fill for every window pixel regardless of colour.

Structure
REQ-030 SHALL place the direction one-hot encodings, the 12-bit colour type and the default TRANSPARENT key in the shared package view_pkg.
REQ-031 SHALL implement the orientation and address arithmetic (REQ-022, REQ-023) in sub-module sprite_addr_gen; frame tick, animation, shadow registers and pipeline stay in sprite_view.

Verification
REQ-032 SHALL cover: xpos=100, ypos=50, right, ROM returning its address -> fill high exactly for hC 100..129 and vC 50..79, delayed ROM_LAT+2 cycles; corner (130,80) has fill=0.
REQ-033 SHALL cover: left at hC=100, vC=50 -> rom_addr=29; up at hC=101, vC=50 -> rom_addr=30; down at hC=100, vC=50 -> rom_addr=870.
REQ-034 SHALL cover: moving=1 held for 32 frame ticks -> anim_frame 0,1,2,3,0, stepping every 8 ticks; moving=0 -> anim_frame unchanged.
REQ-035 SHALL cover: direction changed to 4'b0011 mid-frame, and xpos changed mid-frame -> shadow values unchanged until the next tick; the invalid direction is never adopted.
REQ-036 SHALL cover: xpos=1010 -> window ends at hC=1023 with no wrap to hC 0..15.
REQ-037 SHALL cover: rst pulsed mid-line -> outputs 0 immediately; with SPRITE_TRANSPARENCY_EN, rom_data=12'h000 -> fill=0.
